conversor_bin_bcd: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Sits directly upstream of the per-digit 7-segment converters: each 4-bit nibble of `digitos` drives one decimal display converter, so any binary quantity (score, timer, counter) can be shown in decimal. It uses a start/busy/done handshake and holds its output stable between conversions.

---
 rtl/conversor_bin_bcd.sv | 100 ++++++++++
 1 files changed

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define CONV_BCD_SATURA_EN to force all-9s digits when the value does not fit.
module conversor_bin_bcd #(
  parameter int unsigned LARGURA = 14,
  parameter int unsigned DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic [LARGURA-1:0]     valor,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   digitos,
  output logic                   estouro
);

  localparam int unsigned BcdW = 4 * DIGITOS;
  localparam int unsigned CntW = $clog2(LARGURA + 1);

  function automatic logic [31:0] pot10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] Limite = pot10(DIGITOS);

  typedef enum logic {StOcioso, StDesloca} estado_e;

  estado_e              estado_q;
  logic [LARGURA-1:0]   desloc_q;
  logic [LARGURA-1:0]   desloc_d;
  logic [BcdW-1:0]      scratch_q;
  logic [BcdW-1:0]      scratch_d;
  logic [BcdW-1:0]      ajustado;
  logic [CntW-1:0]      cont_q;
  logic                 estouro_hold_q;
  logic [BcdW+LARGURA-1:0] janela;

  // Add-3 correction per digit, then shift {scratch, value} left; the top bit falls off.
  always_comb begin
    ajustado = scratch_q;
    for (int unsigned d = 0; d < DIGITOS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        ajustado[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
    janela = {ajustado, desloc_q} << 1;
  end

  assign scratch_d = janela[BcdW+LARGURA-1:LARGURA];
  assign desloc_d  = janela[LARGURA-1:0];
  assign ocupado   = (estado_q == StDesloca);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= StOcioso;
      desloc_q       <= '0;
      scratch_q      <= '0;
      cont_q         <= '0;
      estouro_hold_q <= 1'b0;
      pronto         <= 1'b0;
      digitos        <= '0;
      estouro        <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado_q)
        StOcioso: begin
          if (iniciar) begin
            desloc_q       <= valor;
            scratch_q      <= '0;
            cont_q         <= CntW'(LARGURA);
            estouro_hold_q <= (32'(valor) >= Limite);
            estado_q       <= StDesloca;
          end
        end
        StDesloca: begin
          desloc_q  <= desloc_d;
          scratch_q <= scratch_d;
          cont_q    <= cont_q - CntW'(1);
          if (cont_q == CntW'(1)) begin
`ifdef CONV_BCD_SATURA_EN
            digitos <= estouro_hold_q ? {DIGITOS{4'h9}} : scratch_d;
`else
            digitos <= scratch_d;
`endif
            estouro  <= estouro_hold_q;
            pronto   <= 1'b1;
            estado_q <= StOcioso;
          end
        end
        default: estado_q <= StOcioso;
      endcase
    end
  end

endmodule
